// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with one-shot and auto-reload modes; pulses done on terminal count.
// Optional pause input enabled by defining DOWN_COUNTER_TIMER_PAUSE_EN.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic             pause_s;

`ifdef DOWN_COUNTER_TIMER_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // State, count, reload value and done pulse registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      count_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      count_r  <= count_nxt_s;
      reload_r <= reload_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  // Next-state logic: load outranks stop, stop outranks pause, pause outranks counting
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    reload_nxt_s = reload_r;
    done_nxt_s   = 1'b0;
    if (load) begin
      reload_nxt_s = load_val;
      count_nxt_s  = load_val;
      state_nxt_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (count_r == CNT_ZERO) begin
              done_nxt_s = 1'b1;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (stop) begin
            state_nxt_s = IDLE;
          end else if (pause_s) begin
            state_nxt_s = RUN;
          end else if (count_r > CNT_ONE) begin
            count_nxt_s = count_r - CNT_ONE;
          end else if (count_r == CNT_ONE) begin
            count_nxt_s = CNT_ZERO;
            done_nxt_s  = 1'b1;
            state_nxt_s = auto_reload ? RUN : IDLE;
          end else if (!auto_reload) begin
            state_nxt_s = IDLE;
          end else begin
            // A zero reload value means the timer expires on every cycle
            count_nxt_s = reload_r;
            done_nxt_s  = (reload_r == CNT_ZERO);
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    count = count_r;
    busy  = (state_r == RUN);
    done  = done_r;
    zero  = (count_r == CNT_ZERO);
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter timer; the count-down counterpart to the team's up-counter.
- Software or an FSM loads a value and starts the timer. The block decrements once per clock to zero, then pulses `done`.
- Supports one-shot and auto-reload (periodic tick) modes.
- Used as a timeout and tick generator beside the counter blocks.

Parameters:
- WIDTH, 4, width of count and load value (minimum 2).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- load  input  1  load request; sampled on posedge.
- load_val  input  WIDTH  value captured on load.
- start  input  1  start/resume request; sampled on posedge.
- stop  input  1  halt request; sampled on posedge.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled each cycle.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  1 while in RUN (registered).
- done  output  1  one-cycle pulse on terminal count (registered).
- zero  output  1  combinational, (count == 0).

Behaviour:
- Reset (rst=0, async): count=0, reload_reg=0, busy=0, done=0, state=IDLE. Reset mid-count aborts immediately with no `done`. Outputs stay at reset values until the first posedge after rst=1.
- States: IDLE, RUN. busy = (state == RUN).
- `done` defaults to 0 every cycle unless set below.
- Priority per edge: load > stop > start/terminal/decrement.
- load=1 (any state):
  - reload_reg <= load_val, count <= load_val, state <= IDLE.
  - A simultaneous stop/start is ignored.
- stop=1 (RUN):
  - state <= IDLE, count holds, no `done`, even if count == 1 that edge.
- IDLE, start=1, count != 0: state <= RUN. count unchanged on this edge (latency: first decrement is the next edge).
- IDLE, start=1, count == 0: done <= 1 for one cycle, stay IDLE. A zero-length timer expires at once.
- RUN, count > 1: count <= count - 1.
- RUN, count == 1:
  - count <= 0, done <= 1.
  - If auto_reload=0: state <= IDLE (busy falls on the same edge `done` rises).
  - If auto_reload=1: stay RUN.
- RUN, count == 0 (only reachable in auto_reload):
  - count <= reload_reg, no `done`.
  - Period = reload_reg + 1 cycles between `done` pulses.
  - If auto_reload drops while count == 0: state <= IDLE, count stays 0.
  - If reload_reg == 0 in RUN: `done` every cycle while auto_reload=1.
- start while RUN: ignored (no restart).
- start after stop: resumes from held count; reload_reg is unaffected.
- No wrap below zero: count never decrements from 0; it always reloads or idles.
- Arithmetic is unsigned WIDTH-bit. load_val all-ones (15 for WIDTH=4) counts 15 cycles to `done`.

Optional Feature:
- Macro: DOWN_COUNTER_TIMER_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - In RUN with pause=1 and no load/stop: count holds, busy stays 1, no `done`, no reload.
  - pause ranks below stop and above decrement/terminal handling.
  - pause is ignored in IDLE.
- Undefined: port `pause` does not exist; behaviour is exactly as above.

Test Plan (WIDTH=4):
- Reset: drive rst=0 for 2 cycles mid-run with count=7, busy=1 -> count=0, busy=0, done=0 immediately (before next posedge); IDLE after release.
- One-shot: load 5, then start at edge t0 -> count 5 at t0; 4, 3, 2, 1 at t1..t4; count=0, done=1, busy=0 at t5; done=0 at t6; count stays 0.
- Auto-reload: load 3, auto_reload=1, start -> done pulses every 4 cycles; count sequence 3,2,1,0,3,2,1,0; busy=1 throughout; drop auto_reload at count 0 -> IDLE, count 0.
- Stop/resume: load 9, start, stop when count=6 -> count holds 6, busy=0, no done; start again -> 5..0, done once.
- Priority: same edge load=1 (load_val=4), stop=1, start=1 while RUN at count=1 -> count=4, IDLE, done=0. Separately, stop with count=1 -> count holds 1, done=0. start with count=0 -> single done pulse, busy stays 0.
- Pause (DOWN_COUNTER_TIMER_PAUSE_EN defined): load 4, start, pause=1 for 3 cycles at count=2 -> count holds 2, busy=1; release -> 1, 0 with done; total 7 cycles from start edge to done.
